// File: rtl/darkpablo_pkg.sv
// Shared types and constants for the pablo-bus SRAM slave.
// The FSM state names carry a PAB_ prefix so they cannot collide with the WAIT parameter.
package darkpablo_pkg;

    localparam int PAB_DW  = 32;
    localparam int PAB_BEW = 4;

    localparam logic [PAB_DW-1:0] PAB_ERRDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        PAB_IDLE  = 2'd0,
        PAB_WAIT  = 2'd1,
        PAB_RESP  = 2'd2,
        PAB_DRAIN = 2'd3
    } pab_state_t;

endpackage

// File: rtl/darkpablo_sram_array.sv
// Word-organised block RAM built from four independent 8-bit lanes.
// Synchronous read; a lane is written only when its WE bit is set.
module darkpablo_sram_array
    import darkpablo_pkg::*;
#(
    parameter int MLEN = 10
) (
    input  logic               CLK,
    input  logic               EN,
    input  logic [PAB_BEW-1:0] WE,
    input  logic [MLEN-1:0]    ADDR,
    input  logic [PAB_DW-1:0]  WDATA,
    output logic [PAB_DW-1:0]  RDATA
);

    localparam int DEPTH = 1 << MLEN;

    for (genvar lane = 0; lane < PAB_BEW; lane++) begin : g_lane
        logic [7:0] mem [DEPTH];

        always_ff @(posedge CLK) begin
            if (EN) begin
                if (WE[lane]) begin
                    mem[ADDR] <= WDATA[8*lane +: 8];
                end
                RDATA[8*lane +: 8] <= mem[ADDR];
            end
        end
    end

endmodule

// File: rtl/darkpablo_sram.sv
// Pablo-bus memory slave: request latch, wait-state timer, range decode and response FSM
// in front of a byte-lane block RAM.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// PAB_IDLE  | MEM_READY high, waiting for PAB_VALID
// PAB_WAIT  | request latched, timer counting down; access at terminal count
// PAB_RESP  | array result available, drive the one-cycle response
// PAB_DRAIN | wait for the master to drop PAB_VALID before re-arming
module darkpablo_sram
    import darkpablo_pkg::*;
#(
    parameter int                MLEN    = 10,
    parameter logic [PAB_DW-1:0] BASE    = 32'h0000_0000,
    parameter int                WAIT    = 2,
    parameter logic [PAB_DW-1:0] ERRDATA = PAB_ERRDATA
) (
    input  logic               CLK,
    input  logic               RES_N,
    input  logic [PAB_DW-1:0]  PAB_ADDR,
    input  logic               PAB_RD,
    input  logic               PAB_WR,
    input  logic               PAB_VALID,
    input  logic [PAB_DW-1:0]  PAB_DATA,
    input  logic [PAB_BEW-1:0] PAB_BE,
    output logic               MEM_READY,
    output logic               MEM_VALID,
    output logic [PAB_DW-1:0]  MEM_DATA,
    output logic               ERR
);

    localparam logic [PAB_DW:0] SPAN = 33'(4) << MLEN;

    pab_state_t state, state_d;

    logic [3:0]         cnt, cnt_d;
    logic               ready_d, valid_d, err_d;
    logic [PAB_DW-1:0]  data_d;

    // Latched copy of the accepted request; PAB_* may change freely afterwards.
    logic [MLEN-1:0]    lat_idx, lat_idx_d;
    logic               lat_rd, lat_rd_d;
    logic               lat_wr, lat_wr_d;
    logic               lat_inr, lat_inr_d;
    logic [PAB_DW-1:0]  lat_data, lat_data_d;
    logic [PAB_BEW-1:0] lat_be, lat_be_d;

    logic [PAB_DW-1:0]  offset;
    logic               in_range;

    logic               arr_access;
    logic               arr_en;
    logic [PAB_BEW-1:0] arr_we;
    logic [PAB_DW-1:0]  arr_rdata;

    assign offset   = PAB_ADDR - BASE;
    assign in_range = {1'b0, offset} < SPAN;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        ready_d    = MEM_READY;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        data_d     = MEM_DATA;
        lat_idx_d  = lat_idx;
        lat_rd_d   = lat_rd;
        lat_wr_d   = lat_wr;
        lat_inr_d  = lat_inr;
        lat_data_d = lat_data;
        lat_be_d   = lat_be;
        arr_access = 1'b0;

        case (state)
            PAB_IDLE: begin
                ready_d = 1'b1;
                if (MEM_READY && PAB_VALID) begin
                    lat_idx_d  = offset[MLEN+1:2];
                    lat_rd_d   = PAB_RD;
                    lat_wr_d   = PAB_WR;
                    lat_inr_d  = in_range;
                    lat_data_d = PAB_DATA;
                    lat_be_d   = PAB_BE;
                    cnt_d      = 4'(WAIT);
                    ready_d    = 1'b0;
                    state_d    = PAB_WAIT;
                end
            end

            PAB_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_d = cnt - 4'd1;
                end else begin
                    arr_access = 1'b1;
                    state_d    = PAB_RESP;
                end
            end

            PAB_RESP: begin
                valid_d = 1'b1;
                if (lat_wr) begin
                    data_d = '0;
                    err_d  = !lat_inr || lat_rd;
                end else if (lat_rd) begin
                    data_d = lat_inr ? arr_rdata : ERRDATA;
                    err_d  = !lat_inr;
                end else begin
                    data_d = '0;
                end
                state_d = PAB_DRAIN;
            end

            PAB_DRAIN: begin
                if (!PAB_VALID) begin
                    ready_d = 1'b1;
                    state_d = PAB_IDLE;
                end
            end

            default: begin
                state_d = PAB_IDLE;
            end
        endcase
    end

    // Access edges that coincide with reset must not commit a write.
    assign arr_en = arr_access && RES_N;
    assign arr_we = (lat_wr && lat_inr) ? lat_be : '0;

    always_ff @(posedge CLK) begin
        if (!RES_N) begin
            state     <= PAB_IDLE;
            cnt       <= '0;
            MEM_READY <= 1'b0;
            MEM_VALID <= 1'b0;
            MEM_DATA  <= '0;
            ERR       <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            MEM_READY <= ready_d;
            MEM_VALID <= valid_d;
            MEM_DATA  <= data_d;
            ERR       <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        lat_idx  <= lat_idx_d;
        lat_rd   <= lat_rd_d;
        lat_wr   <= lat_wr_d;
        lat_inr  <= lat_inr_d;
        lat_data <= lat_data_d;
        lat_be   <= lat_be_d;
    end

    darkpablo_sram_array #(
        .MLEN (MLEN)
    ) u_array (
        .CLK   (CLK),
        .EN    (arr_en),
        .WE    (arr_we),
        .ADDR  (lat_idx),
        .WDATA (lat_data),
        .RDATA (arr_rdata)
    );

endmodule

// File: tb/tb_darkpablo_sram.sv
// Bench for darkpablo_sram: directed scenarios plus random traffic against a word-array model
// that tracks which bytes have been written.
module tb_darkpablo_sram;

    localparam int          MLEN    = 10;
    localparam int          WORDS   = 1 << MLEN;
    localparam logic [31:0] BASE    = 32'h0000_0000;
    localparam int          WAIT    = 2;
    localparam logic [31:0] ERRDATA = 32'hDEAD_BEEF;

    logic        CLK = 1'b0;
    logic        RES_N;
    logic [31:0] PAB_ADDR;
    logic        PAB_RD;
    logic        PAB_WR;
    logic        PAB_VALID;
    logic [31:0] PAB_DATA;
    logic [3:0]  PAB_BE;
    logic        MEM_READY;
    logic        MEM_VALID;
    logic [31:0] MEM_DATA;
    logic        ERR;

    always #5 CLK = ~CLK;

    darkpablo_sram #(
        .MLEN    (MLEN),
        .BASE    (BASE),
        .WAIT    (WAIT),
        .ERRDATA (ERRDATA)
    ) dut (
        .CLK       (CLK),
        .RES_N     (RES_N),
        .PAB_ADDR  (PAB_ADDR),
        .PAB_RD    (PAB_RD),
        .PAB_WR    (PAB_WR),
        .PAB_VALID (PAB_VALID),
        .PAB_DATA  (PAB_DATA),
        .PAB_BE    (PAB_BE),
        .MEM_READY (MEM_READY),
        .MEM_VALID (MEM_VALID),
        .MEM_DATA  (MEM_DATA),
        .ERR       (ERR)
    );

    logic [31:0] mem_m [WORDS];
    logic [3:0]  known_m [WORDS];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: decode the byte address and apply the access to the word array.
    task automatic model_txn(input logic [31:0] addr, input logic rd, input logic wr,
                             input logic [31:0] data, input logic [3:0] be,
                             output logic [31:0] exp_data, output logic exp_err,
                             output logic [31:0] mask);
        logic [31:0] off;
        bit          inr;
        int          idx;
        off  = addr - BASE;
        inr  = off < 32'(WORDS * 4);
        idx  = int'(off / 4);
        mask = 32'hFFFF_FFFF;
        if (wr) begin
            exp_data = 32'h0;
            exp_err  = !inr || rd;
            if (inr) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem_m[idx][8*i +: 8] = data[8*i +: 8];
                        known_m[idx][i]      = 1'b1;
                    end
                end
            end
        end else if (rd) begin
            exp_err = !inr;
            if (inr) begin
                exp_data = mem_m[idx];
                for (int i = 0; i < 4; i++) begin
                    if (!known_m[idx][i]) mask[8*i +: 8] = 8'h00;
                end
            end else begin
                exp_data = ERRDATA;
            end
        end else begin
            exp_data = 32'h0;
            exp_err  = 1'b0;
        end
    endtask

    // One master transaction. Entered and left at #1 after a rising edge.
    task automatic txn(input logic [31:0] addr, input logic rd, input logic wr,
                       input logic [31:0] data, input logic [3:0] be,
                       input int hold, input bit early, output logic [31:0] got);
        logic [31:0] exp_data, mask;
        logic        exp_err;
        int          t, k;
        logic        extra;
        t = 0;
        while (!MEM_READY && t < 50) begin
            @(posedge CLK); #1;
            t++;
        end
        chk("ready_wait", 32'(MEM_READY), 32'd1);
        PAB_ADDR  = addr;
        PAB_RD    = rd;
        PAB_WR    = wr;
        PAB_DATA  = data;
        PAB_BE    = be;
        PAB_VALID = 1'b1;
        @(posedge CLK); #1;
        PAB_ADDR = $urandom;
        PAB_DATA = $urandom;
        PAB_BE   = 4'($urandom);
        PAB_RD   = 1'($urandom);
        PAB_WR   = 1'($urandom);
        chk("ready_low", 32'(MEM_READY), 32'd0);
        model_txn(addr, rd, wr, data, be, exp_data, exp_err, mask);
        for (k = 1; k <= 40; k++) begin
            if (early && k == 2) PAB_VALID = 1'b0;
            @(posedge CLK); #1;
            if (MEM_VALID) break;
        end
        chk("latency", 32'(k), 32'(WAIT + 2));
        got = MEM_DATA;
        if (mask != 32'h0) chk("data", MEM_DATA & mask, exp_data & mask);
        chk("err", 32'(ERR), 32'(exp_err));
        extra = 1'b0;
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge CLK); #1;
                extra = extra | MEM_VALID;
                chk("drain_busy", 32'(MEM_READY), 32'd0);
            end
        end
        PAB_VALID = 1'b0;
        @(posedge CLK); #1;
        extra = extra | MEM_VALID;
        chk("one_pulse", 32'(extra), 32'd0);
        chk("ready_back", 32'(MEM_READY), 32'd1);
        chk("err_pulse", 32'(ERR), 32'd0);
        if (mask != 32'h0) chk("data_hold", MEM_DATA & mask, exp_data & mask);
    endtask

    initial begin
        logic [31:0] got;
        logic        seen;
        logic [31:0] addr;
        int          sel;

        for (int i = 0; i < WORDS; i++) begin
            mem_m[i]   = 32'h0;
            known_m[i] = 4'h0;
        end
        RES_N     = 1'b0;
        PAB_ADDR  = 32'h0;
        PAB_RD    = 1'b0;
        PAB_WR    = 1'b0;
        PAB_VALID = 1'b0;
        PAB_DATA  = 32'h0;
        PAB_BE    = 4'h0;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ready", 32'(MEM_READY), 32'd0);
        chk("rst_valid", 32'(MEM_VALID), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_data", MEM_DATA, 32'h0);
        RES_N = 1'b1;
        @(posedge CLK); #1;
        chk("ready_after_rst", 32'(MEM_READY), 32'd1);

        txn(32'h10, 1'b0, 1'b1, 32'h1234_5678, 4'hF, 0, 1'b0, got);
        chk("wr_data_zero", got, 32'h0);
        txn(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, 0, 1'b0, got);
        chk("rd_basic", got, 32'h1234_5678);

        txn(32'h20, 1'b0, 1'b1, 32'hAABB_CCDD, 4'hF, 0, 1'b0, got);
        txn(32'h20, 1'b0, 1'b1, 32'h1122_3344, 4'b0101, 1, 1'b0, got);
        txn(32'h22, 1'b1, 1'b0, 32'h0, 4'h0, 0, 1'b0, got);
        chk("be_merge", got, 32'hAA22_CC44);
        txn(32'h20, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'h0, 0, 1'b0, got);
        txn(32'h20, 1'b1, 1'b0, 32'h0, 4'h0, 0, 1'b0, got);
        chk("be_none", got, 32'hAA22_CC44);

        txn(32'h0, 1'b0, 1'b1, 32'h0BAD_F00D, 4'hF, 0, 1'b0, got);
        txn(32'h1000, 1'b1, 1'b0, 32'h0, 4'hF, 0, 1'b0, got);
        chk("oor_rd", got, ERRDATA);
        txn(32'h1000, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, got);
        txn(32'h0, 1'b1, 1'b0, 32'h0, 4'hF, 0, 1'b0, got);
        chk("oor_no_wrap", got, 32'h0BAD_F00D);

        txn(32'h30, 1'b1, 1'b1, 32'hCAFE_0001, 4'hF, 0, 1'b0, got);
        txn(32'h30, 1'b0, 1'b0, 32'h5555_5555, 4'hF, 0, 1'b0, got);
        txn(32'h30, 1'b1, 1'b0, 32'h0, 4'hF, 5, 1'b0, got);
        chk("rdwr_commit", got, 32'hCAFE_0001);
        txn(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, 0, 1'b1, got);
        chk("early_drop", got, 32'h1234_5678);

        // Reset while the timer is running: the write must never land.
        txn(32'h40, 1'b0, 1'b1, 32'h0000_0055, 4'hF, 0, 1'b0, got);
        PAB_ADDR  = 32'h40;
        PAB_RD    = 1'b0;
        PAB_WR    = 1'b1;
        PAB_DATA  = 32'h9999_9999;
        PAB_BE    = 4'hF;
        PAB_VALID = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RES_N     = 1'b0;
        PAB_VALID = 1'b0;
        seen      = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
            seen = seen | MEM_VALID;
        end
        chk("rst_mid_ready", 32'(MEM_READY), 32'd0);
        RES_N = 1'b1;
        repeat (6) begin
            @(posedge CLK); #1;
            seen = seen | MEM_VALID;
        end
        chk("rst_mid_novalid", 32'(seen), 32'd0);
        txn(32'h40, 1'b1, 1'b0, 32'h0, 4'hF, 0, 1'b0, got);
        chk("rst_mid_nowrite", got, 32'h0000_0055);

        for (int n = 0; n < 250; n++) begin
            sel = int'($urandom_range(0, 19));
            if (sel < 16) addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            else if (sel < 18) addr = 32'h1000 + 32'($urandom_range(0, 255));
            else addr = $urandom;
            sel = int'($urandom_range(0, 9));
            txn(addr, sel < 5 || sel == 9, sel >= 5, $urandom, 4'($urandom),
                int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, got);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/darkpablo_sram.md
Name: darkpablo_sram

Overview:
- Memory-side slave for the pablo shared-memory bus. Consumes the single request stream produced by the multi-core memory arbiter: PAB_ADDR, PAB_RD, PAB_WR, PAB_VALID, PAB_DATA, PAB_BE.
- Returns MEM_READY, MEM_VALID and MEM_DATA.
- Holds a word-organised on-chip SRAM with byte-enable writes, programmable wait states and out-of-range address detection.
- Sits between the arbiter and the physical block RAM; it is the only target on the bus.

Parameters:
- MLEN, 10, log2 of memory depth in 32-bit words (default 1024 words = 4 KB).
- BASE, 32'h0000_0000, byte address of word 0; must be aligned to 4*2^MLEN.
- WAIT, 2, wait states inserted before the access, legal range 0..15.
- ERRDATA, 32'hDEADBEEF, data returned on an out-of-range read.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RES_N  in  1  reset, synchronous, active-low.
- PAB_ADDR  in  32  byte address; bits [1:0] are ignored.
- PAB_RD  in  1  read request qualifier.
- PAB_WR  in  1  write request qualifier.
- PAB_VALID  in  1  request valid; held by the master until it sees MEM_VALID.
- PAB_DATA  in  32  write data.
- PAB_BE  in  4  byte enables; bit n controls PAB_DATA[8n+7:8n].
- MEM_READY  out  1  slave idle and able to accept a request.
- MEM_VALID  out  1  one-cycle response strobe.
- MEM_DATA  out  32  read data; valid while MEM_VALID is high, held until the next response.
- ERR  out  1  pulses with MEM_VALID when the access was out of range or had conflicting RD/WR.

Behaviour:
- All outputs are registered.
- Reset (RES_N=0 at an edge) forces:
  - state=IDLE, MEM_READY=0, MEM_VALID=0, ERR=0, MEM_DATA=0, wait counter=0.
  - SRAM contents are not cleared.
- MEM_READY becomes 1 at the first edge with RES_N=1. It is 1 exactly while state==IDLE (registered on entry).
- States:
  - IDLE: at an edge with PAB_VALID=1:
    - latch addr/rd/wr/data/be and the in-range flag;
    - set counter=WAIT, MEM_READY<=0, go to WAIT.
  - WAIT: counter!=0 -> decrement. counter==0 -> issue the array access (synchronous read, or byte-masked write when in range), go to RESP.
  - RESP: set MEM_VALID<=1, MEM_DATA and ERR per the rules below, go to DRAIN.
  - DRAIN: MEM_VALID<=0. Stay while PAB_VALID=1. When PAB_VALID=0, go to IDLE with MEM_READY<=1. This prevents re-serving a request whose VALID is still asserted after the response (the master drops VALID one cycle after sampling MEM_VALID).
- Latency:
  - PAB_VALID sampled in IDLE at edge E0 gives MEM_VALID high for the single cycle following edge E0+WAIT+2.
  - WAIT=0 gives response 2 edges after acceptance.
- In range: (PAB_ADDR - BASE) < 4*2^MLEN, computed as unsigned 32-bit. Word index = (PAB_ADDR-BASE)[MLEN+1:2].
- Read: MEM_DATA = array word; ERR=0.
- Write: array lanes with BE=1 are updated; lanes with BE=0 are untouched. MEM_DATA=0, ERR=0.
- BE=0000 write: no array change; a normal response is still given.
- Out of range:
  - no array write;
  - MEM_DATA = ERRDATA for reads, 0 for writes;
  - ERR=1.
- RD=1 and WR=1 together: treated as a write, ERR=1.
- RD=0 and WR=0 with VALID=1: null transaction; MEM_DATA=0, ERR=0, response timing unchanged.
- PAB_* changing after acceptance is ignored, because the latched copy is used.
- Reset mid-transaction: the transaction is abandoned.
  - A write is committed only if the access edge already occurred.
  - No MEM_VALID is emitted after reset.
- PAB_VALID dropping early (in WAIT) does not abort; the response is still produced, and DRAIN exits immediately.

Decomposition:
- darkpablo_pkg: state enum (IDLE, WAIT, RESP, DRAIN as 2-bit typedef pab_state_t), PAB_DW=32, PAB_BEW=4, default ERRDATA constant.
- Sub-module darkpablo_sram_array:
  - 2^MLEN x 32 block RAM as four 8-bit lanes;
  - ports CLK, EN, WE[3:0], ADDR[MLEN-1:0], WDATA, RDATA;
  - synchronous read, no reset.
- FSM, counter and decode stay in the top module.

Test Plan:
- Reset then idle: RES_N low 3 cycles -> MEM_READY=0, MEM_VALID=0. After release, MEM_READY=1 at the next edge.
- Write then read, WAIT=2:
  - write 0x12345678 to 0x10, BE=1111, then read 0x10;
  - expect MEM_VALID 4 edges after each acceptance, MEM_DATA=0x12345678, ERR=0, exactly one MEM_VALID pulse per request.
- Byte enables: write 0xAABBCCDD to 0x20 with BE=1111, then 0x11223344 with BE=0101, then read -> 0xAA22CC44.
- Out of range with MLEN=10, BASE=0: read 0x0000_1000 -> MEM_DATA=0xDEADBEEF, ERR=1. A write there leaves word 0 unchanged.
- VALID held long: master holds PAB_VALID 5 extra cycles after MEM_VALID -> no second MEM_VALID; MEM_READY returns 1 one edge after VALID falls.
- Reset in WAIT: write accepted, RES_N low during WAIT -> no MEM_VALID. A later read of that address returns the prior contents.
